// File: rtl/msg_display_pkg.sv
// Shared types and constants for the rotating message display.
// Anode patterns are active-low; digit 0 is the leftmost digit.
package msg_display_pkg;

  localparam int MSG_LEN_DEF = 16;

  typedef logic [1:0] digit_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic {
    RUN,
    LOAD
  } state_t;

  localparam nibble_t ANODE_BLANK = 4'b1111;
  localparam nibble_t AN_DIG0     = 4'b0111;
  localparam nibble_t AN_DIG1     = 4'b1011;
  localparam nibble_t AN_DIG2     = 4'b1101;
  localparam nibble_t AN_DIG3     = 4'b1110;

  function automatic nibble_t default_msg(
    input int i
  );
    return nibble_t'(i % 16);
  endfunction

  function automatic nibble_t an_of(
    input digit_t d
  );
    nibble_t a;
    a = ANODE_BLANK;
    unique case (1'b1)
      (d == 2'd0): a = AN_DIG0;
      (d == 2'd1): a = AN_DIG1;
      (d == 2'd2): a = AN_DIG2;
      (d == 2'd3): a = AN_DIG3;
    endcase
    return a;
  endfunction

  // offset < len and digit <= 3 < len, so a single subtract wraps
  function automatic logic [3:0] wrap_idx(
    input logic [3:0] off,
    input digit_t     d,
    input int         len
  );
    logic [4:0] s;
    s = {1'b0, off} + {3'b000, d};
    if (s >= 5'(len)) s = s - 5'(len);
    return s[3:0];
  endfunction

endpackage

// File: rtl/msg_rotate_scan_ctrl_scan_tick_gen.sv
// Digit slot timer: counts 0..DIGIT_CYCLES-1 and flags the last cycle.
// clr holds the counter at zero and masks the tick.
module scan_tick_gen #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int CW = (DIGIT_CYCLES > 1) ?
                     $clog2(DIGIT_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          digit_tick,
  output logic [CW-1:0] cnt
);

  logic last;

  assign last = (cnt == CW'(DIGIT_CYCLES - 1));
  assign digit_tick = last && !clr;

  // slot counter, wraps at the end of each digit slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/msg_rotate_scan_ctrl.sv
// 4-digit multiplexed display sequencer with rotating message window.
// Optional anode dead time: define MSG_ROTATE_ANODE_DEADTIME_EN.
module msg_rotate_scan_ctrl
  import msg_display_pkg::*;
#(
  parameter int MSG_LEN      = MSG_LEN_DEF,
  parameter int DIGIT_CYCLES = 50000,
  parameter int ROT_FRAMES   = 250,
  parameter int DEAD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  output logic       load_ready,
  output logic [3:0] an,
  output logic [3:0] char,
  output logic       rot_tick
);

  localparam int CW = (DIGIT_CYCLES > 1) ?
                      $clog2(DIGIT_CYCLES) : 1;
  localparam int FW = (ROT_FRAMES > 1) ?
                      $clog2(ROT_FRAMES) : 1;

  if (DEAD_CYCLES >= DIGIT_CYCLES) begin : g_bad_dead
    $error("DEAD_CYCLES must be below DIGIT_CYCLES");
  end

  state_t        state;
  digit_t        digit;
  logic [FW-1:0] frame;
  logic [3:0]    offset;
  logic [3:0]    wr_ptr;
  nibble_t       msg [MSG_LEN];

  logic          scan_clr;
  logic          digit_tick;
  logic [CW-1:0] cnt;
  logic          frame_end;
  logic          rotate;
  logic          accept;
  logic          last_nib;
  logic [3:0]    off_next;
  nibble_t       slot_an;

  assign scan_clr  = (state == LOAD) || load_start;
  assign frame_end = digit_tick && (digit == 2'd3);
  assign rotate    = frame_end &&
                     (frame == FW'(ROT_FRAMES - 1));
  assign accept    = (state == LOAD) &&
                     load_valid && load_ready;
  assign last_nib  = (wr_ptr == 4'(MSG_LEN - 1));
  assign off_next  = (offset == 4'(MSG_LEN - 1)) ?
                     4'd0 : offset + 4'd1;

`ifdef MSG_ROTATE_ANODE_DEADTIME_EN
  assign slot_an = (cnt < CW'(DEAD_CYCLES)) ?
                   ANODE_BLANK : an_of(digit);
`else
  assign slot_an = an_of(digit);
`endif

  scan_tick_gen #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .CW           (CW)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .clr        (scan_clr),
    .digit_tick (digit_tick),
    .cnt        (cnt)
  );

  // scan/rotate sequencing, reload handling and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      digit      <= '0;
      frame      <= '0;
      offset     <= '0;
      wr_ptr     <= '0;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= default_msg(i);
      end
      an         <= ANODE_BLANK;
      char       <= 4'h0;
      load_ready <= 1'b0;
      rot_tick   <= 1'b0;
    end else begin
      rot_tick <= 1'b0;
      unique case (1'b1)
        (state == RUN): begin
          if (load_start) begin
            state      <= LOAD;
            an         <= ANODE_BLANK;
            load_ready <= 1'b1;
            wr_ptr     <= '0;
            digit      <= '0;
            frame      <= '0;
          end else begin
            an   <= slot_an;
            char <= msg[wrap_idx(offset, digit, MSG_LEN)];
            if (digit_tick) digit <= digit + 2'd1;
            if (frame_end) begin
              frame <= rotate ? '0 : frame + FW'(1);
            end
            if (rotate) begin
              offset   <= off_next;
              rot_tick <= 1'b1;
            end
          end
        end
        (state == LOAD): begin
          an <= ANODE_BLANK;
          if (accept) begin
            msg[wr_ptr] <= load_data;
            if (last_nib) begin
              state      <= RUN;
              load_ready <= 1'b0;
              wr_ptr     <= '0;
              offset     <= '0;
              frame      <= '0;
              digit      <= '0;
            end else begin
              wr_ptr <= wr_ptr + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_rotate_scan_ctrl.sv
// Self-checking bench for msg_rotate_scan_ctrl.
// Also valid with MSG_ROTATE_ANODE_DEADTIME_EN defined.
module tb_msg_rotate_scan_ctrl;

  localparam int DC   = 4;
  localparam int RF   = 2;
  localparam int L    = 16;
  localparam int DEAD = 1;
  localparam int ROT  = DC * 4 * RF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = 4'h0;
  logic       load_ready;
  logic [3:0] an;
  logic [3:0] chr;
  logic       rot_tick;

  always #5 clk = ~clk;

  msg_rotate_scan_ctrl #(
    .MSG_LEN      (L),
    .DIGIT_CYCLES (DC),
    .ROT_FRAMES   (RF),
    .DEAD_CYCLES  (DEAD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .an         (an),
    .char       (chr),
    .rot_tick   (rot_tick)
  );

  int errs = 0;
  int checks = 0;

  bit         m_run;
  int         m_t;
  int         m_k;
  logic [3:0] m_msg [L];
  logic [3:0] e_an;
  logic [3:0] e_ch;
  logic       e_rt;
  logic       e_rdy;
  bit         e_chk_ch;
  logic [3:0] anp [4];

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] ch;
    logic       rt;
  } vec_t;
  vec_t tab [19];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b1;
    m_t = 0;
    m_k = 0;
    for (int i = 0; i < L; i++) m_msg[i] = 4'(i);
    e_an = 4'hF;
    e_ch = 4'h0;
    e_rt = 1'b0;
    e_rdy = 1'b0;
    e_chk_ch = 1'b1;
  endtask

  // outputs expected after the coming edge, from the time since restart
  task automatic model_step();
    int d;
    int off;
    if (m_run) begin
      if (load_start) begin
        m_run = 1'b0;
        m_k = 0;
        e_an = 4'hF;
        e_rt = 1'b0;
        e_rdy = 1'b1;
        e_chk_ch = 1'b0;
      end else begin
        d = (m_t / DC) % 4;
        off = (m_t / ROT) % L;
        e_an = anp[d];
`ifdef MSG_ROTATE_ANODE_DEADTIME_EN
        if ((m_t % DC) < DEAD) e_an = 4'hF;
`endif
        e_ch = m_msg[(off + d) % L];
        e_chk_ch = 1'b1;
        e_rt = ((m_t + 1) % ROT) == 0;
        e_rdy = 1'b0;
        m_t++;
      end
    end else begin
      e_an = 4'hF;
      e_rt = 1'b0;
      e_chk_ch = 1'b0;
      e_rdy = 1'b1;
      if (load_valid) begin
        m_msg[m_k] = load_data;
        m_k++;
        if (m_k == L) begin
          m_run = 1'b1;
          m_t = 0;
          e_rdy = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    if (e_chk_ch) chk("char", 32'(chr), 32'(e_ch));
    chk("rot_tick", 32'(rot_tick), 32'(e_rt));
    chk("load_ready", 32'(load_ready), 32'(e_rdy));
  endtask

  initial begin
    logic [3:0] ss;
    int n;
    int g;
    bit stall;

    anp[0] = 4'b0111;
    anp[1] = 4'b1011;
    anp[2] = 4'b1101;
    anp[3] = 4'b1110;

    tab[0]  = '{2,   4'b0111, 4'h0, 1'b0};
    tab[1]  = '{4,   4'b0111, 4'h0, 1'b0};
    tab[2]  = '{6,   4'b1011, 4'h1, 1'b0};
    tab[3]  = '{8,   4'b1011, 4'h1, 1'b0};
    tab[4]  = '{10,  4'b1101, 4'h2, 1'b0};
    tab[5]  = '{14,  4'b1110, 4'h3, 1'b0};
    tab[6]  = '{16,  4'b1110, 4'h3, 1'b0};
    tab[7]  = '{18,  4'b0111, 4'h0, 1'b0};
    tab[8]  = '{32,  4'b1110, 4'h3, 1'b1};
    tab[9]  = '{34,  4'b0111, 4'h1, 1'b0};
    tab[10] = '{38,  4'b1011, 4'h2, 1'b0};
    tab[11] = '{42,  4'b1101, 4'h3, 1'b0};
    tab[12] = '{46,  4'b1110, 4'h4, 1'b0};
    tab[13] = '{450, 4'b0111, 4'hE, 1'b0};
    tab[14] = '{454, 4'b1011, 4'hF, 1'b0};
    tab[15] = '{458, 4'b1101, 4'h0, 1'b0};
    tab[16] = '{462, 4'b1110, 4'h1, 1'b0};
    tab[17] = '{514, 4'b0111, 4'h0, 1'b0};
    tab[18] = '{518, 4'b1011, 4'h1, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_char", 32'(chr), 32'h0);
    chk("rst_rot", 32'(rot_tick), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);
    reset = 1'b1;

    for (int k = 1; k <= 520; k++) begin
      step();
      foreach (tab[i]) begin
        if (tab[i].cyc == k) begin
          chk("tab_an", 32'(an), 32'(tab[i].an));
          chk("tab_char", 32'(chr), 32'(tab[i].ch));
          chk("tab_rot", 32'(rot_tick), 32'(tab[i].rt));
        end
      end
      if (k == 1 || k == 5) begin
`ifdef MSG_ROTATE_ANODE_DEADTIME_EN
        ss = 4'hF;
`else
        ss = (k == 1) ? 4'b0111 : 4'b1011;
`endif
        chk("slot_start_an", 32'(an), 32'(ss));
      end
    end

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ld_ready_on", 32'(load_ready), 32'h1);
    n = 0;
    for (int i = 0; i < 40 && n < 16; i++) begin
      stall = (i == 3 || i == 8 || i == 12);
      load_start = (i == 6);
      load_valid = !stall;
      load_data = 4'(15 - n);
      chk("ld_an_blank", 32'(an), 32'hF);
      chk("ld_ready", 32'(load_ready), 32'h1);
      step();
      if (!stall) n++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    chk("ld_count", 32'(n), 32'd16);
    chk("ld_ready_off", 32'(load_ready), 32'h0);
    for (int j = 1; j <= 14; j++) begin
      step();
      if (j % 4 == 2) begin
        chk("ld_char", 32'(chr), 32'(15 - (j / 4)));
      end
    end

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 4'hA;
    repeat (5) step();
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_ready", 32'(load_ready), 32'h0);
    chk("mid_rst_char", 32'(chr), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      if (j % 4 == 2) begin
        chk("post_rst_char", 32'(chr), 32'(j / 4));
        chk("post_rst_ready", 32'(load_ready), 32'h0);
      end
    end

    g = 0;
    while (!(m_run && ((m_t + 1) % ROT) == 0) && g < 200) begin
      step();
      g++;
    end
    chk("coll_reach", 32'(g < 200), 32'h1);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("coll_rot", 32'(rot_tick), 32'h0);
    chk("coll_ready", 32'(load_ready), 32'h1);
    g = 0;
    while (!m_run && g < 200) begin
      load_valid = 1'($urandom % 2);
      load_data = 4'($urandom);
      step();
      g++;
    end
    load_valid = 1'b0;
    chk("coll_done", 32'(m_run), 32'h1);
    repeat (40) step();

    for (int c = 0; c < 900; c++) begin
      if (m_run) begin
        load_start = ($urandom % 60) == 0;
        load_valid = 1'($urandom % 2);
      end else begin
        load_start = ($urandom % 8) == 0;
        load_valid = ($urandom % 4) != 0;
      end
      load_data = 4'($urandom);
      step();
    end
    load_start = 1'b0;
    load_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/msg_rotate_scan_ctrl.md
Name: msg_rotate_scan_ctrl

Overview:
Sequencer for a 4-digit multiplexed 7-segment display with a MSG_LEN-nibble message buffer. It time-multiplexes the anodes and feeds the external hex-to-7-segment decoder one 4-bit char at a time. It rotates the visible window by one character after a constant delay. The message is reloadable through a valid/ready nibble stream. The block sits between the board-level message source and the combinational segment decoder.

Parameters:
MSG_LEN, 16, message length in nibbles (4..16)
DIGIT_CYCLES, 50000, clk cycles each digit is driven
ROT_FRAMES, 250, complete 4-digit scan frames between rotations
DEAD_CYCLES, 8, anode blanking cycles per digit slot (used only with ANODE_DEADTIME_EN, < DIGIT_CYCLES)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
load_start  in  1  single-cycle pulse: begin message reload
load_valid  in  1  load_data is valid
load_data  in  4  message nibble, index order 0..MSG_LEN-1
load_ready  out  1  block accepts nibble this cycle
an  out  4  anode enables, active-low; an[3] = leftmost digit (digit 0)
char  out  4  nibble for decoder of currently enabled digit
rot_tick  out  1  one-cycle pulse when window offset advances

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, scan cnt=0, digit=0, frame=0, offset=0, wr_ptr=0.
  - msg[i]=i mod 16.
  - an=4'b1111, char=4'h0, load_ready=0, rot_tick=0.
- All outputs are registered. an and char reflect internal digit/offset/state with 1-cycle latency.
- RUN:
  - cnt counts 0..DIGIT_CYCLES-1 and wraps.
  - At wrap, digit advances 0->1->2->3->0.
  - an = one-hot-low of digit: 0111, 1011, 1101, 1110. char = msg[(offset+digit) mod MSG_LEN].
  - On digit 3->0 wrap (frame end), frame increments.
  - At frame end with frame==ROT_FRAMES-1: frame=0, offset=(offset+1) mod MSG_LEN, rot_tick=1 for exactly one cycle.
  - offset wraps MSG_LEN-1 -> 0.
- RUN -> LOAD on load_start=1:
  - Next cycle: an=1111, load_ready=1, wr_ptr=0.
  - Scan counters are held at 0.
- LOAD:
  - Each cycle with load_valid & load_ready: msg[wr_ptr]=load_data, wr_ptr++.
  - load_valid=0 cycles are stalls with no write.
  - On the MSG_LEN-th accepted nibble: state=RUN, load_ready=0 the next cycle, offset=frame=digit=cnt=0.
  - First displayed char after exit is msg[0].
- Simultaneous events:
  - load_start in the same cycle as a rotation frame end: load wins, rot_tick suppressed, offset unchanged.
  - load_start while in LOAD: ignored.
  - load_valid while in RUN: ignored, no write.
- Reset mid-LOAD: partially written buffer is discarded and the default pattern restored.
- Width rules:
  - cnt is $clog2(DIGIT_CYCLES) bits; frame is $clog2(ROT_FRAMES) bits.
  - offset and wr_ptr are 4 bits. Modulo MSG_LEN uses explicit compare-and-wrap, not power-of-two truncation.

Optional Feature:
- Macro: MSG_ROTATE_ANODE_DEADTIME_EN.
- Defined: in RUN, an=1111 while cnt<DEAD_CYCLES in every digit slot. char still updates at the slot start. This removes ghosting on digit change.
- Undefined: the anode is driven for the full DIGIT_CYCLES slot and DEAD_CYCLES is unused.

Decomposition:
- Package msg_display_pkg holds:
  - MSG_LEN default, digit-index typedef (2 bits), nibble typedef (4 bits).
  - Anode pattern constants ANODE_BLANK=4'b1111 and AN_DIG0..AN_DIG3.
  - Default message function (msg[i]=i).
  - State enum {RUN, LOAD}.
- One sub-module, scan_tick_gen:
  - Holds the DIGIT_CYCLES counter and outputs a 1-cycle digit_tick plus cnt (the latter for deadtime).
  - Top instantiates it; the segment decoder stays external.

Test Plan:
All scenarios use DIGIT_CYCLES=4, ROT_FRAMES=2, MSG_LEN=16, DEAD_CYCLES=1.
- Release reset -> an=1111 for 1 cycle, then an 0111/1011/1101/1110 for 4 cycles each, with char 0,1,2,3; rot_tick=0.
- Run 32 cycles past reset -> rot_tick single-cycle pulse; next frame shows char 1,2,3,4.
- Run 14 rotations (offset=14) -> frame shows char E,F,0,1; after 2 more rotations offset=0, showing 0,1,2,3.
- Reload with a stall:
  - Stimulus: load_start, then 16 nibbles F..0 with load_valid low on 3 interleaved cycles.
  - Response: an=1111 and load_ready=1 throughout; exactly 16 writes; afterwards chars F,E,D,C.
  - A load_start pulse issued mid-load is ignored.
- Reset mid-load:
  - Stimulus: assert reset after 5 accepted nibbles (A,A,A,A,A), then release.
  - Response: chars 0,1,2,3; state RUN; load_ready=0.
- Collision and deadtime:
  - load_start on the rotation frame-end cycle -> rot_tick stays 0 and offset is unchanged.
  - With MSG_ROTATE_ANODE_DEADTIME_EN defined -> first cycle of each slot has an=1111.
